// File: rtl/pong_score_text.sv
// Pong score/status text formatter: converts both scores to BCD by shift-add-3,
// builds the two 16-character LCD lines, and commits all eight words on one edge.
module pong_score_text (
    input  logic        lcdclk,
    input  logic        reset,
    input  logic        update,
    input  logic [7:0]  score_p1,
    input  logic [7:0]  score_p2,
    input  logic [1:0]  game_state,
    output logic        busy,
    output logic        done,
    output logic [31:0] reg_a,
    output logic [31:0] reg_b,
    output logic [31:0] reg_c,
    output logic [31:0] reg_d,
    output logic [31:0] reg_e,
    output logic [31:0] reg_f,
    output logic [31:0] reg_g,
    output logic [31:0] reg_h
);

    typedef enum logic [1:0] {IDLE, CONV, FORMAT, COMMIT} state_e;

    localparam logic [255:0] DEFAULT_SCREEN = {"P1:  0    P2:  0", "PRESS START     "};

    state_e       state_q;
    logic         pending_q;
    logic         busy_q;
    logic         done_q;
    logic [2:0]   step_q;
    logic [7:0]   p1_bin_q;
    logic [7:0]   p2_bin_q;
    logic [11:0]  p1_bcd_q;
    logic [11:0]  p2_bcd_q;
    logic [1:0]   gs_q;
    logic [255:0] stage_q;
    logic [255:0] screen_q;

    logic [19:0]  p1_shift_d;
    logic [19:0]  p2_shift_d;
    logic [127:0] line1_d;
    logic [127:0] line2_d;
    logic         start_d;

    function automatic logic [11:0] add3(input logic [11:0] bcd);
        logic [11:0] r;
        r = bcd;
        for (int n = 0; n < 3; n++) begin
            if (bcd[4*n +: 4] >= 4'd5) r[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Hundreds blank when zero; tens blank only when hundreds is blank too.
    function automatic logic [23:0] score_chars(input logic [11:0] bcd);
        logic [7:0] h_ch;
        logic [7:0] t_ch;
        logic [7:0] u_ch;
        h_ch = (bcd[11:8] == 4'd0) ? 8'h20 : {4'h3, bcd[11:8]};
        t_ch = (bcd[11:4] == 8'd0) ? 8'h20 : {4'h3, bcd[7:4]};
        u_ch = {4'h3, bcd[3:0]};
        return {h_ch, t_ch, u_ch};
    endfunction

    // NOTE: every variable assigned here gets a value on every path, so no latch is inferred.
    always_comb begin
        p1_shift_d = {add3(p1_bcd_q), p1_bin_q} << 1;
        p2_shift_d = {add3(p2_bcd_q), p2_bin_q} << 1;
        line1_d    = {"P1:", score_chars(p1_bcd_q), "    P2:", score_chars(p2_bcd_q)};
        line2_d    = "PRESS START     ";
        case (gs_q)
            2'd1:    line2_d = "PLAYING         ";
            2'd2:    line2_d = "PLAYER 1 WINS!  ";
            2'd3:    line2_d = "PLAYER 2 WINS!  ";
            default: line2_d = "PRESS START     ";
        endcase
        start_d = update | pending_q;
    end

    // NOTE: only control state and the visible screen are reset; the working
    // registers are always reloaded in IDLE before anything reads them.
    always_ff @(posedge lcdclk) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            screen_q  <= DEFAULT_SCREEN;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_d) begin
                        p1_bin_q  <= score_p1;
                        p2_bin_q  <= score_p2;
                        gs_q      <= game_state;
                        p1_bcd_q  <= 12'd0;
                        p2_bcd_q  <= 12'd0;
                        step_q    <= 3'd0;
                        pending_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= CONV;
                    end
                end
                CONV: begin
                    p1_bcd_q <= p1_shift_d[19:8];
                    p1_bin_q <= p1_shift_d[7:0];
                    p2_bcd_q <= p2_shift_d[19:8];
                    p2_bin_q <= p2_shift_d[7:0];
                    step_q   <= step_q + 3'd1;
                    if (step_q == 3'd7) state_q <= FORMAT;
                    if (update) pending_q <= 1'b1;
                end
                FORMAT: begin
                    stage_q <= {line1_d, line2_d};
                    state_q <= COMMIT;
                    if (update) pending_q <= 1'b1;
                end
                COMMIT: begin
                    // A pending or fresh request keeps busy high; IDLE restarts on the next edge.
                    screen_q  <= stage_q;
                    done_q    <= 1'b1;
                    busy_q    <= start_d;
                    pending_q <= start_d;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign {reg_a, reg_b, reg_c, reg_d, reg_e, reg_f, reg_g, reg_h} = screen_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
